// File: rtl/bank_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bank_arbiter_pkg
// Purpose  : Shared constants for the bank arbiter: requester indices and
//            the bank muxcode encoding, plus an index-to-muxcode helper.
// Revision : 1.0 - initial release
// ============================================================================
package bank_arbiter_pkg;

  // Requester indices; the position in the packed req/addr buses.
  localparam int REQ_I = 0;
  localparam int REQ_D = 1;
  localparam int REQ_C = 2;

  // Muxcode presented to the bank for each requester.
  typedef enum logic [1:0] {
    MUX_I = 2'b00,
    MUX_D = 2'b01,
    MUX_C = 2'b10
  } muxcode_e;

  // Map a requester index onto the bank muxcode.
  function automatic logic [1:0] idx_to_mux(input int idx);
    logic [1:0] mux;
    case (idx)
      REQ_I:   mux = MUX_I;
      REQ_D:   mux = MUX_D;
      REQ_C:   mux = MUX_C;
      default: mux = 2'b00;
    endcase
    return mux;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bank_arbiter_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb
// Purpose  : Combinational N-way round-robin arbiter. Grants the first
//            requester at or after the priority pointer (modulo N) and
//            reports the pointer value to load if that grant is taken.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb
  import bank_arbiter_pkg::*;
#(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_idx,
  output logic          o_any,
  output logic [PW-1:0] o_nxt_ptr
);

  int w_k;

  // Rotating priority search starting at the pointer.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_k   = 0;
    for (int i = 0; i < N; i++) begin
      w_k = (int'(i_ptr) + i) % N;
      if (!o_any && i_req[w_k[PW-1:0]]) begin
        o_gnt[w_k[PW-1:0]] = 1'b1;
        o_idx              = w_k[PW-1:0];
        o_any              = 1'b1;
      end
    end
  end

  // Pointer moves one past the winner, wrapping at N.
  always_comb begin
    o_nxt_ptr = (o_idx == PW'(N - 1)) ? '0 : o_idx + PW'(1);
  end

endmodule
`default_nettype wire

// File: rtl/bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bank_arbiter
// Purpose  : Independent round-robin arbitration of the read and write ports
//            of a shared bank among the interface, data and compute
//            requesters. Read data valid follows a read grant by one cycle.
// Config   : BANK_ARB_RAW_STALL_EN - when defined, a same-cycle read and
//            write to one address defers the read by a cycle (writes are
//            blocked in that cycle so the read sees the written data).
// Revision : 1.0 - initial release
// ============================================================================
module bank_arbiter
  import bank_arbiter_pkg::*;
#(
  parameter int A = 10,
  parameter int N = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   rd_req,
  input  logic [N*A-1:0] rd_addr,
  output logic [N-1:0]   rd_gnt,
  output logic [N-1:0]   rd_vld,
  input  logic [N-1:0]   wr_req,
  input  logic [N*A-1:0] wr_addr,
  output logic [N-1:0]   wr_gnt,
  output logic           bank_rd_en,
  output logic [A-1:0]   bank_rd_addr,
  output logic [1:0]     bank_rd_muxcode,
  output logic           bank_wr_en,
  output logic [A-1:0]   bank_wr_addr,
  output logic [1:0]     bank_wr_muxcode
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [N-1:0]  r_rd_vld;
  logic          r_stall;

  logic [N-1:0]  w_rd_gnt_raw;
  logic [PW-1:0] w_rd_idx;
  logic          w_rd_any_raw;
  logic [PW-1:0] w_rd_nxt;
  logic [N-1:0]  w_wr_gnt_raw;
  logic [PW-1:0] w_wr_idx;
  logic          w_wr_any_raw;
  logic [PW-1:0] w_wr_nxt;

  logic [N-1:0]  w_rd_gnt;
  logic [N-1:0]  w_wr_gnt;
  logic [A-1:0]  w_rd_addr_sel;
  logic [A-1:0]  w_wr_addr_sel;
  logic          w_conflict;

  rr_arb #(.N(N), .PW(PW)) u_rd_arb (
    .i_req     (rd_req),
    .i_ptr     (r_rd_ptr),
    .o_gnt     (w_rd_gnt_raw),
    .o_idx     (w_rd_idx),
    .o_any     (w_rd_any_raw),
    .o_nxt_ptr (w_rd_nxt)
  );

  rr_arb #(.N(N), .PW(PW)) u_wr_arb (
    .i_req     (wr_req),
    .i_ptr     (r_wr_ptr),
    .o_gnt     (w_wr_gnt_raw),
    .o_idx     (w_wr_idx),
    .o_any     (w_wr_any_raw),
    .o_nxt_ptr (w_wr_nxt)
  );

  // Final grants: reset blocks everything; a pending stall blocks writes;
  // a read-after-write address match (when enabled) blocks the read.
  always_comb begin
    w_rd_addr_sel = rd_addr[int'(w_rd_idx)*A +: A];
    w_wr_addr_sel = wr_addr[int'(w_wr_idx)*A +: A];
    w_wr_gnt      = (rst || r_stall) ? '0 : w_wr_gnt_raw;
`ifdef BANK_ARB_RAW_STALL_EN
    w_conflict    = !rst && w_rd_any_raw && (|w_wr_gnt) &&
                    (w_rd_addr_sel == w_wr_addr_sel);
`else
    w_conflict    = 1'b0;
`endif
    w_rd_gnt      = (rst || w_conflict) ? '0 : w_rd_gnt_raw;
  end

  // Bank port drive: address and muxcode of the winner, zero when idle.
  always_comb begin
    rd_gnt          = w_rd_gnt;
    wr_gnt          = w_wr_gnt;
    rd_vld          = r_rd_vld;
    bank_rd_en      = |w_rd_gnt;
    bank_wr_en      = |w_wr_gnt;
    bank_rd_addr    = bank_rd_en ? w_rd_addr_sel : '0;
    bank_wr_addr    = bank_wr_en ? w_wr_addr_sel : '0;
    bank_rd_muxcode = bank_rd_en ? idx_to_mux(int'(w_rd_idx)) : 2'b00;
    bank_wr_muxcode = bank_wr_en ? idx_to_mux(int'(w_wr_idx)) : 2'b00;
  end

  // Pointers advance only on an issued grant; read valid tracks the bank's
  // one-cycle read latency; the stall flag lives for a single cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_rd_vld <= '0;
      r_stall  <= 1'b0;
    end else begin
      if (|w_rd_gnt) r_rd_ptr <= w_rd_nxt;
      if (|w_wr_gnt) r_wr_ptr <= w_wr_nxt;
      r_rd_vld <= w_rd_gnt;
      r_stall  <= w_conflict;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bank_arbiter
// Purpose  : Directed bench for bank_arbiter. Expected read-valid values are
//            queued when a step is driven and popped after the next edge.
//            Honours BANK_ARB_RAW_STALL_EN for the same-address case.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bank_arbiter;

  localparam int A = 10;
  localparam int N = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   rd_req;
  logic [N*A-1:0] rd_addr;
  logic [N-1:0]   rd_gnt;
  logic [N-1:0]   rd_vld;
  logic [N-1:0]   wr_req;
  logic [N*A-1:0] wr_addr;
  logic [N-1:0]   wr_gnt;
  logic           bank_rd_en;
  logic [A-1:0]   bank_rd_addr;
  logic [1:0]     bank_rd_muxcode;
  logic           bank_wr_en;
  logic [A-1:0]   bank_wr_addr;
  logic [1:0]     bank_wr_muxcode;

  int n_pass  = 0;
  int n_total = 0;
  logic [N-1:0] exp_vld_q[$];

  bank_arbiter #(.A(A), .N(N)) dut (
    .clk             (clk),
    .rst             (rst),
    .rd_req          (rd_req),
    .rd_addr         (rd_addr),
    .rd_gnt          (rd_gnt),
    .rd_vld          (rd_vld),
    .wr_req          (wr_req),
    .wr_addr         (wr_addr),
    .wr_gnt          (wr_gnt),
    .bank_rd_en      (bank_rd_en),
    .bank_rd_addr    (bank_rd_addr),
    .bank_rd_muxcode (bank_rd_muxcode),
    .bank_wr_en      (bank_wr_en),
    .bank_wr_addr    (bank_wr_addr),
    .bank_wr_muxcode (bank_wr_muxcode)
  );

  always #5 clk = ~clk;

  // Hard stop in case the sequence never completes.
  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [N*A-1:0] pk(input logic [A-1:0] ai, input logic [A-1:0] ad,
                                        input logic [A-1:0] ac);
    return {ac, ad, ai};
  endfunction

  // One cycle: drive, check combinational grants/bank ports, queue the
  // expected read valid, clock, then pop and check read valid.
  task automatic step(input logic [2:0] rq, input logic [N*A-1:0] ra,
                      input logic [2:0] wq, input logic [N*A-1:0] wa,
                      input logic [2:0] erg, input logic [A-1:0] era, input logic [1:0] erm,
                      input logic [2:0] ewg, input logic [A-1:0] ewa, input logic [1:0] ewm);
    rd_req  = rq;
    rd_addr = ra;
    wr_req  = wq;
    wr_addr = wa;
    #2;
    chk("rd_gnt",   32'(rd_gnt),          32'(erg));
    chk("rd_en",    32'(bank_rd_en),      32'(|erg));
    chk("rd_addr",  32'(bank_rd_addr),    32'(era));
    chk("rd_mux",   32'(bank_rd_muxcode), 32'(erm));
    chk("wr_gnt",   32'(wr_gnt),          32'(ewg));
    chk("wr_en",    32'(bank_wr_en),      32'(|ewg));
    chk("wr_addr",  32'(bank_wr_addr),    32'(ewa));
    chk("wr_mux",   32'(bank_wr_muxcode), 32'(ewm));
    exp_vld_q.push_back(erg);
    @(posedge clk);
    #1;
    chk("rd_vld",   32'(rd_vld),          32'(exp_vld_q.pop_front()));
  endtask

  localparam logic [N*A-1:0] Z = '0;

  initial begin
    logic [N*A-1:0] ra3;
    ra3 = pk(10'h010, 10'h020, 10'h030);

    // Reset with requests active: nothing may be granted.
    rst     = 1'b1;
    rd_req  = 3'b111;
    rd_addr = ra3;
    wr_req  = 3'b111;
    wr_addr = ra3;
    @(posedge clk);
    #1;
    chk("rst_rd_gnt",  32'(rd_gnt),          32'd0);
    chk("rst_wr_gnt",  32'(wr_gnt),          32'd0);
    chk("rst_rd_en",   32'(bank_rd_en),      32'd0);
    chk("rst_wr_en",   32'(bank_wr_en),      32'd0);
    chk("rst_rd_addr", 32'(bank_rd_addr),    32'd0);
    chk("rst_wr_addr", 32'(bank_wr_addr),    32'd0);
    chk("rst_rd_mux",  32'(bank_rd_muxcode), 32'd0);
    chk("rst_wr_mux",  32'(bank_wr_muxcode), 32'd0);
    chk("rst_rd_vld",  32'(rd_vld),          32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // All three readers continuously requesting: strict rotation.
    step(3'b111, ra3, 3'b000, Z, 3'b001, 10'h010, 2'b00, 3'b000, 10'h0, 2'b00);
    step(3'b111, ra3, 3'b000, Z, 3'b010, 10'h020, 2'b01, 3'b000, 10'h0, 2'b00);
    step(3'b111, ra3, 3'b000, Z, 3'b100, 10'h030, 2'b10, 3'b000, 10'h0, 2'b00);
    step(3'b111, ra3, 3'b000, Z, 3'b001, 10'h010, 2'b00, 3'b000, 10'h0, 2'b00);
    step(3'b111, ra3, 3'b000, Z, 3'b010, 10'h020, 2'b01, 3'b000, 10'h0, 2'b00);
    step(3'b111, ra3, 3'b000, Z, 3'b100, 10'h030, 2'b10, 3'b000, 10'h0, 2'b00);

    // Writers i and c; c at the top address.
    step(3'b000, Z, 3'b101, pk(10'h001, 10'h000, 10'h3FF),
         3'b000, 10'h0, 2'b00, 3'b001, 10'h001, 2'b00);
    step(3'b000, Z, 3'b101, pk(10'h001, 10'h000, 10'h3FF),
         3'b000, 10'h0, 2'b00, 3'b100, 10'h3FF, 2'b10);

    // Lone requester d gets back-to-back grants.
    step(3'b010, pk(10'h0, 10'h155, 10'h0), 3'b000, Z, 3'b010, 10'h155, 2'b01, 3'b000, 10'h0, 2'b00);
    step(3'b010, pk(10'h0, 10'h155, 10'h0), 3'b000, Z, 3'b010, 10'h155, 2'b01, 3'b000, 10'h0, 2'b00);
    step(3'b010, pk(10'h0, 10'h155, 10'h0), 3'b000, Z, 3'b010, 10'h155, 2'b01, 3'b000, 10'h0, 2'b00);

    // Read pointer now 2: i and d alternate, no repeat while both request.
    step(3'b011, ra3, 3'b000, Z, 3'b001, 10'h010, 2'b00, 3'b000, 10'h0, 2'b00);
    step(3'b011, ra3, 3'b000, Z, 3'b010, 10'h020, 2'b01, 3'b000, 10'h0, 2'b00);
    step(3'b011, ra3, 3'b000, Z, 3'b001, 10'h010, 2'b00, 3'b000, 10'h0, 2'b00);

    // Idle cycle holds the pointer (1); c is then next.
    step(3'b000, Z,   3'b000, Z, 3'b000, 10'h0,   2'b00, 3'b000, 10'h0, 2'b00);
    step(3'b100, ra3, 3'b000, Z, 3'b100, 10'h030, 2'b10, 3'b000, 10'h0, 2'b00);

    // Read i and write c to the same address 0x055 (both pointers at 0).
`ifdef BANK_ARB_RAW_STALL_EN
    step(3'b001, pk(10'h055, 10'h0, 10'h0), 3'b100, pk(10'h0, 10'h0, 10'h055),
         3'b000, 10'h0, 2'b00, 3'b100, 10'h055, 2'b10);
    step(3'b001, pk(10'h055, 10'h0, 10'h0), 3'b001, pk(10'h200, 10'h0, 10'h0),
         3'b001, 10'h055, 2'b00, 3'b000, 10'h0, 2'b00);
`else
    step(3'b001, pk(10'h055, 10'h0, 10'h0), 3'b100, pk(10'h0, 10'h0, 10'h055),
         3'b001, 10'h055, 2'b00, 3'b100, 10'h055, 2'b10);
    step(3'b001, pk(10'h055, 10'h0, 10'h0), 3'b001, pk(10'h200, 10'h0, 10'h0),
         3'b001, 10'h055, 2'b00, 3'b001, 10'h200, 2'b00);
`endif
    step(3'b000, Z, 3'b000, Z, 3'b000, 10'h0, 2'b00, 3'b000, 10'h0, 2'b00);

    // Read c granted (write d alongside moves the write pointer to 2),
    // then reset lands while its read valid is outstanding.
    step(3'b100, ra3, 3'b010, ra3, 3'b100, 10'h030, 2'b10, 3'b010, 10'h020, 2'b01);
    rst = 1'b1;
    #1;
    chk("midrst_rd_vld", 32'(rd_vld), 32'd0);
    rd_req = 3'b111;
    wr_req = 3'b110;
    #1;
    chk("midrst_rd_gnt", 32'(rd_gnt), 32'd0);
    chk("midrst_wr_gnt", 32'(wr_gnt), 32'd0);
    chk("midrst_rd_en",  32'(bank_rd_en), 32'd0);
    @(posedge clk);
    #1;
    chk("midrst_rd_vld_edge", 32'(rd_vld), 32'd0);
    rst = 1'b0;

    // Both pointers back at 0.
    step(3'b111, ra3, 3'b110, ra3, 3'b001, 10'h010, 2'b00, 3'b010, 10'h020, 2'b01);
    step(3'b000, Z,   3'b000, Z,   3'b000, 10'h0,   2'b00, 3'b000, 10'h0,   2'b00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bank_arbiter.md
BANK_ARBITER -- requirements
Module: bank_arbiter

Interface
REQ-001 Parameter a, 10, bank address width; must match the attached bank64k.
REQ-002 Parameter n, 3, number of requesters; index 0 = interface (i), 1 = data (d), 2 = compute (c), matching bank muxcodes 2'b00/2'b01/2'b10.
REQ-003 Port clk  input  1  sole clock, rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port rd_req  input  n  per-requester read request.
REQ-006 Port rd_addr  input  n*a  per-requester read address; requester k occupies bits [k*a +: a].
REQ-007 Port rd_gnt  output  n  one-hot-or-zero read grant.
REQ-008 Port rd_vld  output  n  read data valid on the shared bank read word, one-hot-or-zero.
REQ-009 Port wr_req  input  n  per-requester write request.
REQ-010 Port wr_addr  input  n*a  per-requester write address, packed as rd_addr.
REQ-011 Port wr_gnt  output  n  one-hot-or-zero write grant.
REQ-012 Port bank_rd_en, bank_rd_addr, bank_rd_muxcode  output  1/a/2  drive the bank read port.
REQ-013 Port bank_wr_en, bank_wr_addr, bank_wr_muxcode  output  1/a/2  drive the bank write port.

Function
REQ-014 Read and write ports SHALL be arbitrated independently, each round-robin over n requesters.
REQ-015 Grants SHALL be combinational from requests and the registered priority pointer; the grant is the first requester with req=1 at or after the pointer, modulo n.
REQ-016 On a granted cycle, the pointer SHALL advance to (granted index + 1) mod n; with no grant, it SHALL hold.
REQ-017 bank_*_en SHALL equal OR of the corresponding grant; bank_*_addr and bank_*_muxcode SHALL carry the granted requester's address and index, and SHALL be 0 when no grant is issued.
REQ-018 rd_vld[k] SHALL assert exactly one cycle after rd_gnt[k], matching the bank's one-cycle read latency.
REQ-019 A requester SHALL hold req and addr stable until granted; a request deasserted before grant is dropped without side effects.
REQ-020 Back-to-back grants to the same requester SHALL be allowed only when no other requester is requesting.
REQ-021 With all n requesting continuously, each requester SHALL receive exactly one grant in every n consecutive cycles.

Reset
REQ-022 While rst=1: all grants, bank_rd_en and bank_wr_en = 0; addresses and muxcodes = 0; rd_vld = 0; both pointers = 0; stall flag = 0.
REQ-023 Reset asserted mid-operation SHALL cancel any pending rd_vld; no bank access SHALL be issued in the cycle rst is sampled high.

Configuration
REQ-024 Macro BANK_ARB_RAW_STALL_EN defined: if the read and write grants in one cycle target the same address, the read grant SHALL be suppressed, the read pointer SHALL hold, and a stall flag SHALL be set.
REQ-025 With the stall flag set, all write grants SHALL be suppressed for exactly that next cycle, the stalled read SHALL then be granted, and the flag SHALL clear.
REQ-026 Macro undefined: same-address read and write SHALL both be issued in the same cycle; the read data is then collision-undefined and the arbiter does not track it.

Structure
REQ-027 A shared package SHALL hold the requester index constants (REQ_I=0, REQ_D=1, REQ_C=2) and the muxcode encoding.
REQ-028 One sub-module, rr_arb, SHALL implement a single n-way round-robin arbiter (req, pointer -> grant, next pointer); it SHALL be instantiated twice, once for read and once for write.

Verification
REQ-029 Reset, then rd_req=3'b111 held for 6 cycles -> rd_gnt sequence 001,010,100,001,010,100; rd_vld follows each grant one cycle later.
REQ-030 wr_req=3'b101 with wr_addr c=0x3FF, i=0x001 -> wr_gnt 001 then 100; bank_wr_muxcode 00 then 10; bank_wr_addr 0x001 then 0x3FF.
REQ-031 Single requester d, rd_req=3'b010 held 3 cycles -> rd_gnt 010 on every cycle; bank_rd_muxcode=01.
REQ-032 With BANK_ARB_RAW_STALL_EN, rd_req i and wr_req c both at addr 0x055 -> cycle 0: wr_gnt=100, rd_gnt=000; cycle 1: rd_gnt=001, wr_gnt=000; cycle 2: rd_vld=001.
REQ-033 rst asserted one cycle after rd_gnt=100 -> rd_vld stays 000; pointers return to 0; the first grant after reset goes to requester 0.
